// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcode
// and funct fields, ALUOp classes and ALUControl codes.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        ILLEGAL = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALUOp class plus the funct field
// to an ALUControl code, and flags funct values the ALU cannot execute.
module alu_decoder
    import mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    always_comb begin
        alu_control = ALUC_ADD;
        funct_valid = 1'b1;
        case (aluop)
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUC_ADD;
                    FUNCT_SUB: alu_control = ALUC_SUB;
                    FUNCT_AND: alu_control = ALUC_AND;
                    FUNCT_OR:  alu_control = ALUC_OR;
                    FUNCT_SLT: alu_control = ALUC_SLT;
                    default:   funct_valid = 1'b0;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: sequences memory, PC, register file
// and ALU per instruction, counts retired instructions, traps illegal ones.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             IorD,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic [2:0]       ALUControl,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           cur_state, nxt_state;
    logic [CNT_W-1:0] retired_q;
    aluop_t           aluop;
    logic [2:0]       alu_ctl;
    logic             funct_valid;
    logic             retire;
    logic             ir_w, mem_w, pc_w, br, iord, srca, reg_w, rdst, m2r, ill;
    logic [1:0]       pcsrc, srcb;

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .alu_control (alu_ctl),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
            retired_q <= '0;
        end else begin
            cur_state <= nxt_state;
            if (retire) retired_q <= retired_q + CNT_ONE;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        aluop     = ALUOP_ADD;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        pc_w      = 1'b0;
        br        = 1'b0;
        iord      = 1'b0;
        pcsrc     = 2'b00;
        srca      = 1'b0;
        srcb      = 2'b00;
        reg_w     = 1'b0;
        rdst      = 1'b0;
        m2r       = 1'b0;
        ill       = 1'b0;
        case (cur_state)
            FETCH: begin
                srcb = 2'b01;
                ir_w = mem_ready;
                pc_w = mem_ready;
                if (mem_ready) nxt_state = DECODE;
            end
            DECODE: begin
                srcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_RTYPE:     nxt_state = RTYPEEX;
                    OP_BEQ:       nxt_state = BEQEX;
                    OP_ADDI:      nxt_state = ADDIEX;
                    OP_J:         nxt_state = JEX;
                    default:      nxt_state = ILLEGAL;
                endcase
            end
            MEMADR: begin
                srca      = 1'b1;
                srcb      = 2'b10;
                nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) nxt_state = MEMWB;
            end
            MEMWB: begin
                reg_w     = 1'b1;
                m2r       = 1'b1;
                nxt_state = FETCH;
                retire    = 1'b1;
            end
            // The store holds its strobe until memory accepts it, then retires.
            MEMWR: begin
                iord  = 1'b1;
                mem_w = 1'b1;
                if (mem_ready) begin
                    nxt_state = FETCH;
                    retire    = 1'b1;
                end
            end
            RTYPEEX: begin
                srca      = 1'b1;
                aluop     = ALUOP_FUNCT;
                nxt_state = funct_valid ? RTYPEWB : ILLEGAL;
            end
            RTYPEWB: begin
                reg_w     = 1'b1;
                rdst      = 1'b1;
                nxt_state = FETCH;
                retire    = 1'b1;
            end
            BEQEX: begin
                srca      = 1'b1;
                aluop     = ALUOP_SUB;
                br        = 1'b1;
                pcsrc     = 2'b01;
                nxt_state = FETCH;
                retire    = 1'b1;
            end
            ADDIEX: begin
                srca      = 1'b1;
                srcb      = 2'b10;
                nxt_state = ADDIWB;
            end
            ADDIWB: begin
                reg_w     = 1'b1;
                nxt_state = FETCH;
                retire    = 1'b1;
            end
            JEX: begin
                pc_w      = 1'b1;
                pcsrc     = 2'b10;
                nxt_state = FETCH;
                retire    = 1'b1;
            end
            ILLEGAL: ill = 1'b1;
            default: nxt_state = ILLEGAL;
        endcase
    end

    // Reset gates every output combinationally so nothing writes in the cycle it rises.
    assign IRWrite    = ir_w  & ~reset;
    assign MemWrite   = mem_w & ~reset;
    assign PCWrite    = pc_w  & ~reset;
    assign Branch     = br    & ~reset;
    assign IorD       = iord  & ~reset;
    assign ALUSrcA    = srca  & ~reset;
    assign RegWrite   = reg_w & ~reset;
    assign RegDst     = rdst  & ~reset;
    assign MemtoReg   = m2r   & ~reset;
    assign illegal    = ill   & ~reset;
    assign PCSrc      = reset ? 2'b00 : pcsrc;
    assign ALUSrcB    = reset ? 2'b00 : srcb;
    assign ALUControl = reset ? 3'b000 : alu_ctl;
    assign state      = cur_state;
    assign retired    = retired_q;

endmodule
